// File: rtl/shift_pkg.sv
// Shared definitions for the serial-to-parallel receiver.
// Provides shift-direction codes, collection-phase encoding and the
// bit-counter width helper used by shift_deser and deser_shifter.
package shift_pkg;

  // Shift direction encodings as seen on the dir input.
  localparam logic DIR_LEFT  = 1'b0;  // new bit enters LSB, first bit ends in MSB
  localparam logic DIR_RIGHT = 1'b1;  // new bit enters MSB, first bit ends in LSB

  // Collection phase of the word being assembled (decoded from bit_cnt).
  typedef enum logic {
    ST_IDLE    = 1'b0,  // bit_cnt == 0, next sampled bit starts a word
    ST_COLLECT = 1'b1   // 0 < bit_cnt < WIDTH
  } col_state_t;

  // Counter wide enough to hold values 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/deser_shifter.sv
// Purpose: WIDTH-bit serial shift register with per-word direction latch and bit counter.
// Latency: word/done are combinational off the edge-sampling inputs; state updates on clk.
// Backpressure: none; every sin_valid bit is absorbed, output side decides what to drop.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   clear        synchronous flush of all state
//   sin          serial data bit, sampled when sin_valid is high
//   sin_valid    sample strobe
//   dir          shift direction, latched with the first bit of each word
//   word         the shifted value including the current sin bit
//   done         high when this edge samples the last bit of a word
//   bit_cnt      registered count of bits already collected (never WIDTH)
module deser_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CW = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             dir,
  output logic [WIDTH-1:0] word,
  output logic             done,
  output logic [CW-1:0]    bit_cnt
);

  logic [WIDTH-1:0] sreg;
  logic             dir_q;
  logic             dir_eff;
  logic             last_bit;
  col_state_t       state;
  logic [CW-1:0]    cnt_nxt;

  // Phase is fully determined by bit_cnt; no separate state register needed.
  always_comb begin
    state = ST_IDLE;
    if (bit_cnt != '0) begin
      state = ST_COLLECT;
    end
  end

  // On the first bit of a word the live dir pin governs the shift; after that
  // the latched copy does, so mid-word dir changes have no effect.
  always_comb begin
    dir_eff = dir_q;
    if (state == ST_IDLE) begin
      dir_eff = dir;
    end
  end

  always_comb begin
    word = '0;
    if (dir_eff == DIR_LEFT) begin
      word = {sreg[WIDTH-2:0], sin};
    end else begin
      word = {sin, sreg[WIDTH-1:1]};
    end
  end

  assign last_bit = (bit_cnt == CW'(WIDTH - 1));
  // clear wins over a completing bit, so no word escapes on a flush edge.
  assign done     = sin_valid && last_bit && !clear;

  always_comb begin
    cnt_nxt = bit_cnt + CW'(1);
    if (last_bit) begin
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      dir_q   <= DIR_LEFT;
      bit_cnt <= '0;
    end else if (clear) begin
      sreg    <= '0;
      dir_q   <= DIR_LEFT;
      bit_cnt <= '0;
    end else if (sin_valid) begin
      sreg    <= word;
      bit_cnt <= cnt_nxt;
      if (state == ST_IDLE) begin
        dir_q <= dir;
      end
    end
  end

endmodule

// File: rtl/shift_deser.sv
// Purpose: serial-to-parallel receiver presenting WIDTH-bit words on a valid/ready port.
// Latency: dout/dout_valid update on the edge sampling the WIDTH-th bit.
// Backpressure: one-word holding register; a word completing while it is full and
//               not being consumed is dropped and sets sticky overrun.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   sin, sin_valid, dir   serial input bit, sample strobe, shift direction
//   clear                 synchronous flush of all state (highest priority)
//   dout, dout_valid      completed word and its valid flag
//   dout_ready            consumer accept strobe
//   bit_cnt               bits collected into the word in progress
//   overrun               sticky: a completed word was dropped
module shift_deser
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CW = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             dir,
  input  logic             clear,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun
);

  logic [WIDTH-1:0] word;
  logic             done;
  logic             out_free;

  deser_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .sin       (sin),
    .sin_valid (sin_valid),
    .dir       (dir),
    .word      (word),
    .done      (done),
    .bit_cnt   (bit_cnt)
  );

  // The holding register can take a new word if it is empty or its current
  // word is being consumed on this very edge.
  assign out_free = !dout_valid || dout_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (clear) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (done) begin
      if (out_free) begin
        dout       <= word;
        dout_valid <= 1'b1;
      end else begin
        overrun    <= 1'b1;
      end
    end else if (dout_valid && dout_ready) begin
      // Consumed with nothing new arriving: dout keeps its stale value.
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_deser.sv
module tb_shift_deser;

  localparam int WIDTH = 4;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk;
  logic             rst_n;
  logic             sin;
  logic             sin_valid;
  logic             dir;
  logic             clear;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [CW-1:0]    bit_cnt;
  logic             overrun;

  int checks = 0;
  int errors = 0;

  shift_deser #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .dir        (dir),
    .clear      (clear),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .bit_cnt    (bit_cnt),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Send four bits b[3], b[2], b[1], b[0] on consecutive cycles.
  task automatic send_bits(input logic [3:0] b);
    for (int i = 3; i >= 0; i--) begin
      sin       = b[i];
      sin_valid = 1'b1;
      tick();
    end
    sin_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sin = 1'b0; sin_valid = 1'b0; dir = 1'b0;
    clear = 1'b0; dout_ready = 1'b0;
    tick(); tick();
    check("rst_dout",    32'(dout),       32'h0);
    check("rst_valid",   32'(dout_valid), 32'h0);
    check("rst_bitcnt",  32'(bit_cnt),    32'h0);
    check("rst_overrun", 32'(overrun),    32'h0);
    rst_n = 1'b1;
    tick();

    // Left shift: 1,0,1,1 -> 1011
    dout_ready = 1'b1; dir = 1'b0;
    send_bits(4'b1011);
    check("left_dout",  32'(dout),       32'hB);
    check("left_valid", 32'(dout_valid), 32'h1);
    tick();
    check("left_valid_drop", 32'(dout_valid), 32'h0);

    // Right shift: 1,0,1,1 -> 1101
    dir = 1'b1;
    send_bits(4'b1011);
    check("right_dout",  32'(dout),       32'hD);
    check("right_valid", 32'(dout_valid), 32'h1);
    tick();

    // Right shift with dir toggled after the first bit: still 1101
    sin = 1'b1; sin_valid = 1'b1; dir = 1'b1;
    tick();
    dir = 1'b0; sin = 1'b0;
    tick();
    sin = 1'b1;
    tick();
    tick();
    sin_valid = 1'b0;
    check("dirtoggle_dout",  32'(dout),       32'hD);
    check("dirtoggle_valid", 32'(dout_valid), 32'h1);
    tick();

    // Gaps: 1,1,0,0 with 3 idle cycles between bits
    dir = 1'b0;
    sin = 1'b1; sin_valid = 1'b1; tick(); sin_valid = 1'b0;
    check("gap_cnt1", 32'(bit_cnt), 32'h1);
    tick(); tick(); tick();
    check("gap_hold", 32'(bit_cnt), 32'h1);
    sin = 1'b1; sin_valid = 1'b1; tick(); sin_valid = 1'b0;
    check("gap_cnt2", 32'(bit_cnt), 32'h2);
    tick(); tick(); tick();
    sin = 1'b0; sin_valid = 1'b1; tick(); sin_valid = 1'b0;
    check("gap_cnt3", 32'(bit_cnt), 32'h3);
    check("gap_novalid", 32'(dout_valid), 32'h0);
    tick(); tick(); tick();
    sin = 1'b0; sin_valid = 1'b1; tick(); sin_valid = 1'b0;
    check("gap_cnt0",  32'(bit_cnt),    32'h0);
    check("gap_dout",  32'(dout),       32'hC);
    check("gap_valid", 32'(dout_valid), 32'h1);
    tick();

    // Backpressure: A then 5 with dout_ready low
    dout_ready = 1'b0; dir = 1'b0;
    send_bits(4'hA);
    check("bp_first_dout",    32'(dout),    32'hA);
    check("bp_first_overrun", 32'(overrun), 32'h0);
    send_bits(4'h5);
    check("bp_drop_dout",    32'(dout),       32'hA);
    check("bp_drop_valid",   32'(dout_valid), 32'h1);
    check("bp_drop_overrun", 32'(overrun),    32'h1);
    dout_ready = 1'b1;
    tick();
    check("bp_consume_valid",   32'(dout_valid), 32'h0);
    check("bp_sticky_overrun",  32'(overrun),    32'h1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("bp_clear_overrun", 32'(overrun), 32'h0);

    // Back-to-back 3 then C, consume on the edge C completes
    dout_ready = 1'b0;
    send_bits(4'h3);
    check("b2b_first_dout", 32'(dout), 32'h3);
    sin_valid = 1'b1;
    sin = 1'b1; tick();
    sin = 1'b1; tick();
    sin = 1'b0; tick();
    check("b2b_hold_dout",  32'(dout),       32'h3);
    check("b2b_hold_valid", 32'(dout_valid), 32'h1);
    sin = 1'b0; dout_ready = 1'b1; tick();
    sin_valid = 1'b0;
    check("b2b_second_dout",  32'(dout),       32'hC);
    check("b2b_second_valid", 32'(dout_valid), 32'h1);
    check("b2b_overrun",      32'(overrun),    32'h0);
    tick();
    check("b2b_drain_valid", 32'(dout_valid), 32'h0);

    // Reset mid-word
    dir = 1'b0;
    sin = 1'b1; sin_valid = 1'b1; tick(); tick(); sin_valid = 1'b0;
    check("rstmid_cnt_before", 32'(bit_cnt), 32'h2);
    rst_n = 1'b0;
    #1;
    check("rstmid_dout",   32'(dout),       32'h0);
    check("rstmid_valid",  32'(dout_valid), 32'h0);
    check("rstmid_bitcnt", 32'(bit_cnt),    32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    send_bits(4'b0110);
    check("rstmid_word", 32'(dout), 32'h6);
    check("rstmid_word_valid", 32'(dout_valid), 32'h1);
    tick();

    // Clear mid-word
    sin = 1'b1; sin_valid = 1'b1; tick(); tick(); sin_valid = 1'b0;
    check("clrmid_cnt_before", 32'(bit_cnt), 32'h2);
    clear = 1'b1; sin_valid = 1'b1;
    tick();
    clear = 1'b0; sin_valid = 1'b0;
    check("clrmid_dout",   32'(dout),       32'h0);
    check("clrmid_valid",  32'(dout_valid), 32'h0);
    check("clrmid_bitcnt", 32'(bit_cnt),    32'h0);
    send_bits(4'b0110);
    check("clrmid_word", 32'(dout), 32'h6);
    check("clrmid_word_valid", 32'(dout_valid), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
